// File: rtl/apb_cat_loader_if.sv
// Pixel-stream handshake plus APB bus between the loader (master) and the CatRecognizer side (slave).
interface apb_cat_loader_if #(
   parameter int unsigned AMBA_WORD       = 24,
   parameter int unsigned AMBA_ADDR_DEPTH = 12
);
   logic                     in_valid;
   logic [AMBA_WORD-1:0]     in_data;
   logic                     in_ready;
   logic                     PSEL;
   logic                     PENABLE;
   logic                     PWRITE;
   logic [AMBA_ADDR_DEPTH:0] PADDR;
   logic [AMBA_WORD-1:0]     PWDATA;
   logic [AMBA_WORD-1:0]     PRDATA;

   modport master (
      input  in_valid, in_data, PRDATA,
      output in_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output in_valid, in_data, PRDATA,
      input  in_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_cat_loader.sv
// APB initiator: loads one image of pixel words into the CatRecognizer bank, sets Start,
// polls Start until cleared, then reports CatRecOut as a one-cycle result.
module apb_cat_loader #(
   parameter int unsigned AMBA_WORD       = 24,
   parameter int unsigned AMBA_ADDR_DEPTH = 12,
   parameter int unsigned ITERATION       = 4096,
   parameter int unsigned POLL_GAP        = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     go,
   apb_cat_loader_if.master         bus,
   input  logic                     CatRecOut,
   output logic                     busy,
   output logic                     result_valid,
   output logic                     result,
   output logic [AMBA_ADDR_DEPTH:0] word_count
);
   localparam int unsigned ADDR_W = AMBA_ADDR_DEPTH + 1;
   localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_WAIT_PIX  = 4'd1;
   localparam logic [3:0] S_WR_SETUP  = 4'd2;
   localparam logic [3:0] S_WR_ACCESS = 4'd3;
   localparam logic [3:0] S_ST_GAP    = 4'd4;
   localparam logic [3:0] S_ST_SETUP  = 4'd5;
   localparam logic [3:0] S_ST_ACCESS = 4'd6;
   localparam logic [3:0] S_GAP       = 4'd7;
   localparam logic [3:0] S_RD_SETUP  = 4'd8;
   localparam logic [3:0] S_RD_ACCESS = 4'd9;
   localparam logic [3:0] S_REPORT    = 4'd10;

   logic [3:0]           r_state,      w_state;
   logic                 r_in_ready,   w_in_ready;
   logic                 r_psel,       w_psel;
   logic                 r_penable,    w_penable;
   logic                 r_pwrite,     w_pwrite;
   logic [ADDR_W-1:0]    r_paddr,      w_paddr;
   logic [AMBA_WORD-1:0] r_pwdata,     w_pwdata;
   logic                 r_busy,       w_busy;
   logic                 r_result_valid, w_result_valid;
   logic                 r_result,     w_result;
   logic [ADDR_W-1:0]    r_word_count, w_word_count;
   logic [GAP_W-1:0]     r_gap,        w_gap;
   logic [ADDR_W-1:0]    w_wc_inc;
   logic                 w_unused_prdata;

   // Only the Start bit of the poll read matters.
   assign w_unused_prdata = ^bus.PRDATA[AMBA_WORD-1:1];
   assign w_wc_inc        = r_word_count + ADDR_W'(1);

   // Next state and next registered outputs; every output is registered alongside the state.
   always_comb begin
      w_state        = r_state;
      w_in_ready     = 1'b0;
      w_psel         = 1'b0;
      w_penable      = 1'b0;
      w_pwrite       = 1'b0;
      w_paddr        = '0;
      w_pwdata       = '0;
      w_busy         = r_busy;
      w_result_valid = 1'b0;
      w_result       = r_result;
      w_word_count   = r_word_count;
      w_gap          = '0;
      case (r_state)
         S_IDLE: begin
            if (go) begin
               w_state      = S_WAIT_PIX;
               w_in_ready   = 1'b1;
               w_busy       = 1'b1;
               w_word_count = '0;
            end
         end
         S_WAIT_PIX: begin
            if (bus.in_valid && r_in_ready) begin
               w_state  = S_WR_SETUP;
               w_psel   = 1'b1;
               w_pwrite = 1'b1;
               w_paddr  = w_wc_inc;
               w_pwdata = bus.in_data;
            end else begin
               w_in_ready = 1'b1;
            end
         end
         S_WR_SETUP: begin
            w_state   = S_WR_ACCESS;
            w_psel    = 1'b1;
            w_penable = 1'b1;
            w_pwrite  = 1'b1;
            w_paddr   = r_paddr;
            w_pwdata  = r_pwdata;
         end
         S_WR_ACCESS: begin
            w_word_count = w_wc_inc;
            if (w_wc_inc == ADDR_W'(ITERATION)) begin
               w_state = S_ST_GAP;
            end else begin
               w_state    = S_WAIT_PIX;
               w_in_ready = 1'b1;
            end
         end
         // Idle cycle so PSEL drops between the last pixel write and the Start write.
         S_ST_GAP: begin
            w_state  = S_ST_SETUP;
            w_psel   = 1'b1;
            w_pwrite = 1'b1;
            w_pwdata = AMBA_WORD'(1);
         end
         S_ST_SETUP: begin
            w_state   = S_ST_ACCESS;
            w_psel    = 1'b1;
            w_penable = 1'b1;
            w_pwrite  = 1'b1;
            w_pwdata  = r_pwdata;
         end
         S_ST_ACCESS: begin
            w_state = S_GAP;
         end
         S_GAP: begin
            if (r_gap == GAP_W'(POLL_GAP - 1)) begin
               w_state = S_RD_SETUP;
               w_psel  = 1'b1;
            end else begin
               w_gap = r_gap + GAP_W'(1);
            end
         end
         S_RD_SETUP: begin
            w_state   = S_RD_ACCESS;
            w_psel    = 1'b1;
            w_penable = 1'b1;
         end
         // An unknown Start bit falls into the else branch and keeps polling.
         S_RD_ACCESS: begin
            if (bus.PRDATA[0] == 1'b0) begin
               w_state        = S_REPORT;
               w_result       = CatRecOut;
               w_result_valid = 1'b1;
            end else begin
               w_state = S_GAP;
            end
         end
         S_REPORT: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end
         default: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= S_IDLE;
         r_in_ready     <= 1'b0;
         r_psel         <= 1'b0;
         r_penable      <= 1'b0;
         r_pwrite       <= 1'b0;
         r_paddr        <= '0;
         r_pwdata       <= '0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_result       <= 1'b0;
         r_word_count   <= '0;
         r_gap          <= '0;
      end else begin
         r_state        <= w_state;
         r_in_ready     <= w_in_ready;
         r_psel         <= w_psel;
         r_penable      <= w_penable;
         r_pwrite       <= w_pwrite;
         r_paddr        <= w_paddr;
         r_pwdata       <= w_pwdata;
         r_busy         <= w_busy;
         r_result_valid <= w_result_valid;
         r_result       <= w_result;
         r_word_count   <= w_word_count;
         r_gap          <= w_gap;
      end
   end

   assign bus.in_ready = r_in_ready;
   assign bus.PSEL     = r_psel;
   assign bus.PENABLE  = r_penable;
   assign bus.PWRITE   = r_pwrite;
   assign bus.PADDR    = r_paddr;
   assign bus.PWDATA   = r_pwdata;
   assign busy         = r_busy;
   assign result_valid = r_result_valid;
   assign result       = r_result;
   assign word_count   = r_word_count;
endmodule
